regfile_access_ctrl: RTL and testbench

Sequencer/arbiter in front of the single-op register file (one read-pair or one write per cycle, selected by op). It shares that port between one read requester (decode: rs1/rs2) and two write requesters (ALU writeback, load writeback). After reset it zero-clears all 32 registers, then grants one operation per cycle. Writes have priority; a starvation guard protects reads, and round-robin arbitration is used between the two writers.

---
 rtl/regfile_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file port sequencer: zero-clears every register after reset, then grants one
// read-pair or one write per cycle (writes first, read starvation guard, round-robin writers).
module regfile_access_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int NREGS        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rd_num_1,
  input  logic [4:0]  rd_num_2,
  output logic        rd_rvalid,
  output logic [31:0] rd_data_1,
  output logic [31:0] rd_data_2,
  input  logic        wa_valid,
  output logic        wa_ready,
  input  logic [4:0]  wa_num,
  input  logic [31:0] wa_val,
  input  logic        wl_valid,
  output logic        wl_ready,
  input  logic [4:0]  wl_num,
  input  logic [31:0] wl_val,
  output logic        rf_en,
  output logic        rf_op,
  output logic [4:0]  rf_reg_num_1,
  output logic [4:0]  rf_reg_num_2,
  output logic [4:0]  rf_reg_num,
  output logic [31:0] rf_val,
  input  logic [31:0] rf_rs_1,
  input  logic [31:0] rf_rs_2
);

  // state   | meaning
  // S_CLEAR | writing zero to registers 0..NREGS-1, no grants
  // S_RUN   | arbitrating one register-file operation per cycle
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam int CW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic          r_rr_wl, w_rr_wl_nxt;
  logic          r_rvalid;
  logic [4:0]    r_cap_num_1, r_cap_num_2;
  logic [31:0]   r_hold_1, r_hold_2;
  logic [31:0]   w_data_1, w_data_2;
  logic          w_any_wr, w_rd_win, w_wr_win, w_sel_wl;
  logic [4:0]    w_wr_num;
  logic [31:0]   w_wr_val;

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_starve_nxt  = r_starve;
    w_rr_wl_nxt   = r_rr_wl;
    w_any_wr      = wa_valid | wl_valid;
    w_rd_win      = 1'b0;
    w_wr_win      = 1'b0;
    w_sel_wl      = wl_valid && (!wa_valid || r_rr_wl);
    w_wr_num      = w_sel_wl ? wl_num : wa_num;
    w_wr_val      = w_sel_wl ? wl_val : wa_val;
    rd_ready      = 1'b0;
    wa_ready      = 1'b0;
    wl_ready      = 1'b0;
    rf_en         = 1'b0;
    rf_op         = 1'b0;
    rf_reg_num_1  = 5'd0;
    rf_reg_num_2  = 5'd0;
    rf_reg_num    = 5'd0;
    rf_val        = 32'd0;
    // Outputs are forced quiet while reset is held, even though the state already reads CLEAR.
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        rf_en         = 1'b1;
        rf_op         = 1'b1;
        rf_reg_num    = 5'(r_clr_cnt);
        w_clr_cnt_nxt = r_clr_cnt + CW'(1);
        if (r_clr_cnt == CW'(NREGS - 1)) begin
          w_state_nxt   = S_RUN;
          w_clr_cnt_nxt = '0;
        end
      end else begin
        w_rd_win = rd_valid && (!w_any_wr || (r_starve == SW'(STARVE_LIMIT)));
        w_wr_win = w_any_wr && !w_rd_win;
        if (w_rd_win) begin
          rd_ready     = 1'b1;
          rf_en        = 1'b1;
          rf_reg_num_1 = rd_num_1;
          rf_reg_num_2 = rd_num_2;
        end else if (w_wr_win) begin
          wa_ready   = !w_sel_wl;
          wl_ready   = w_sel_wl;
          rf_op      = 1'b1;
          rf_reg_num = w_wr_num;
          rf_val     = w_wr_val;
          rf_en      = (w_wr_num != 5'd0);
          if (wa_valid && wl_valid) w_rr_wl_nxt = !r_rr_wl;
        end
        if (rd_valid && w_wr_win) begin
          if (r_starve != SW'(STARVE_LIMIT)) w_starve_nxt = r_starve + SW'(1);
        end else begin
          w_starve_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_starve    <= '0;
      r_rr_wl     <= 1'b0;
      r_rvalid    <= 1'b0;
      r_cap_num_1 <= 5'd0;
      r_cap_num_2 <= 5'd0;
      r_hold_1    <= 32'd0;
      r_hold_2    <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_starve  <= w_starve_nxt;
      r_rr_wl   <= w_rr_wl_nxt;
      r_rvalid  <= w_rd_win;
      if (w_rd_win) begin
        r_cap_num_1 <= rd_num_1;
        r_cap_num_2 <= rd_num_2;
      end
      if (r_rvalid) begin
        r_hold_1 <= w_data_1;
        r_hold_2 <= w_data_2;
      end
    end
  end

  // Read data arrives from the register file in the response cycle; it is held afterwards.
  assign w_data_1  = (r_cap_num_1 == 5'd0) ? 32'd0 : rf_rs_1;
  assign w_data_2  = (r_cap_num_2 == 5'd0) ? 32'd0 : rf_rs_2;
  assign rd_rvalid = r_rvalid;
  assign rd_data_1 = r_rvalid ? w_data_1 : r_hold_1;
  assign rd_data_2 = r_rvalid ? w_data_2 : r_hold_2;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file model, grant table, directed corner sequences
// and random traffic checked against an architectural reference model.
module tb_regfile_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, rd_ready, rd_rvalid;
  logic [4:0]  rd_num_1, rd_num_2;
  logic [31:0] rd_data_1, rd_data_2;
  logic        wa_valid, wa_ready, wl_valid, wl_ready;
  logic [4:0]  wa_num, wl_num;
  logic [31:0] wa_val, wl_val;
  logic        rf_en, rf_op;
  logic [4:0]  rf_reg_num_1, rf_reg_num_2, rf_reg_num;
  logic [31:0] rf_val, rf_rs_1, rf_rs_2;

  regfile_access_ctrl #(.STARVE_LIMIT(4), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_num_1(rd_num_1), .rd_num_2(rd_num_2),
    .rd_rvalid(rd_rvalid), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_num(wa_num), .wa_val(wa_val),
    .wl_valid(wl_valid), .wl_ready(wl_ready), .wl_num(wl_num), .wl_val(wl_val),
    .rf_en(rf_en), .rf_op(rf_op), .rf_reg_num_1(rf_reg_num_1), .rf_reg_num_2(rf_reg_num_2),
    .rf_reg_num(rf_reg_num), .rf_val(rf_val), .rf_rs_1(rf_rs_1), .rf_rs_2(rf_rs_2)
  );

  always #5 clk = ~clk;

  // Register file: starts with junk, x0 reads back junk so the DUT must force zero itself.
  logic [31:0] mem [32];
  bit          mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (rf_en && rf_op) begin
      mem[rf_reg_num] <= rf_val;
    end
    if (rf_en && !rf_op) begin
      rf_rs_1 <= (rf_reg_num_1 == 5'd0) ? 32'hBAD0_BAD0 : mem[rf_reg_num_1];
      rf_rs_2 <= (rf_reg_num_2 == 5'd0) ? 32'hBAD0_BAD0 : mem[rf_reg_num_2];
    end else begin
      rf_rs_1 <= $urandom;
      rf_rs_2 <= $urandom;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents plus arbitration bookkeeping.
  logic [31:0] m_regs [32];
  int          m_clr, m_starve, m_rr;
  bit          m_pend;
  logic [31:0] m_p1, m_p2, m_h1, m_h2;

  typedef struct {
    bit rv, av, lv;
    bit e_rd, e_wa, e_wl;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = 0; m_starve = 0; m_rr = 0; m_pend = 0;
    m_p1 = 0; m_p2 = 0; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic set_in(input bit rv, input logic [4:0] n1, input logic [4:0] n2,
                        input bit av, input logic [4:0] an, input logic [31:0] aval,
                        input bit lv, input logic [4:0] ln, input logic [31:0] lval);
    rd_valid = rv; rd_num_1 = n1; rd_num_2 = n2;
    wa_valid = av; wa_num = an; wa_val = aval;
    wl_valid = lv; wl_num = ln; wl_val = lval;
  endtask

  task automatic set_idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a negedge with inputs applied; checks this cycle and advances the model.
  task automatic cyc_check();
    int          g;  // 0 none, 1 read, 2 alu write, 3 load write, 4 clear write
    logic [4:0]  wn;
    logic [31:0] wv;
    #1;
    if (m_pend) begin m_h1 = m_p1; m_h2 = m_p2; end
    chk("rd_rvalid", rd_rvalid, m_pend);
    chk("rd_data_1", rd_data_1, m_h1);
    chk("rd_data_2", rd_data_2, m_h2);
    m_pend = 0;
    if (m_clr < 32) g = 4;
    else if (rd_valid && (!(wa_valid || wl_valid) || m_starve == 4)) g = 1;
    else if (wa_valid && wl_valid) g = (m_rr == 0) ? 2 : 3;
    else if (wa_valid) g = 2;
    else if (wl_valid) g = 3;
    else g = 0;
    chk("rd_ready", rd_ready, g == 1);
    chk("wa_ready", wa_ready, g == 2);
    chk("wl_ready", wl_ready, g == 3);
    case (g)
      4: begin
        chk("clr_rf_en", rf_en, 1);
        chk("clr_rf_op", rf_op, 1);
        chk("clr_rf_reg_num", rf_reg_num, m_clr);
        chk("clr_rf_val", rf_val, 0);
        m_regs[m_clr] = 0;
        m_clr++;
      end
      1: begin
        chk("rd_rf_en", rf_en, 1);
        chk("rd_rf_op", rf_op, 0);
        chk("rf_reg_num_1", rf_reg_num_1, rd_num_1);
        chk("rf_reg_num_2", rf_reg_num_2, rd_num_2);
        m_pend = 1;
        m_p1 = (rd_num_1 == 0) ? 32'd0 : m_regs[rd_num_1];
        m_p2 = (rd_num_2 == 0) ? 32'd0 : m_regs[rd_num_2];
      end
      2, 3: begin
        wn = (g == 2) ? wa_num : wl_num;
        wv = (g == 2) ? wa_val : wl_val;
        chk("wr_rf_op", rf_op, 1);
        chk("wr_rf_en", rf_en, wn != 0);
        chk("wr_rf_reg_num", rf_reg_num, wn);
        chk("wr_rf_val", rf_val, wv);
        if (wn != 0) m_regs[wn] = wv;
        if (wa_valid && wl_valid) m_rr = 1 - m_rr;
      end
      default: chk("idle_rf_en", rf_en, 0);
    endcase
    if (g != 4) begin
      if (rd_valid && (g == 2 || g == 3)) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
      else m_starve = 0;
    end
  endtask

  task automatic tick();
    cyc_check();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_wa_ready", wa_ready, 0);
    chk("rst_wl_ready", wl_ready, 0);
    chk("rst_rf_en", rf_en, 0);
    chk("rst_rf_op", rf_op, 0);
    chk("rst_rf_reg_num", rf_reg_num, 0);
    chk("rst_rf_val", rf_val, 0);
    chk("rst_rd_rvalid", rd_rvalid, 0);
    chk("rst_rd_data_1", rd_data_1, 0);
    chk("rst_rd_data_2", rd_data_2, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in($urandom_range(0, 99) < 60, 5'($urandom), 5'($urandom),
             $urandom_range(0, 99) < 50, 5'($urandom), $urandom,
             $urandom_range(0, 99) < 50, 5'($urandom), $urandom);
      tick();
    end
  endtask

  initial begin
    // Starting from rr=ALU, starve=0: dual writers alternate, starvation forces the 5th read.
    tbl[0]  = '{0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 0};
    tbl[3]  = '{0, 1, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 1};
    tbl[6]  = '{1, 1, 1, 0, 1, 0};
    tbl[7]  = '{1, 1, 1, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 1, 0};
    tbl[9]  = '{1, 0, 1, 0, 0, 1};
    tbl[10] = '{1, 1, 1, 1, 0, 0};
    tbl[11] = '{1, 1, 1, 0, 1, 0};
    tbl[12] = '{0, 1, 1, 0, 0, 1};
    tbl[13] = '{1, 1, 0, 0, 1, 0};
    tbl[14] = '{1, 0, 0, 1, 0, 0};

    set_idle();
    do_reset();

    // Clear sweep; requests in the second half must not be granted.
    for (int i = 0; i < 32; i++) begin
      if (i >= 16) set_in(1, 5, 31, 1, 7, 32'h1111_1111, 1, 9, 32'h2222_2222);
      cyc_check();
      chk("clear_index", rf_reg_num, i);
      @(negedge clk);
    end

    set_in(1, 5, 31, 0, 0, 0, 0, 0, 0);
    tick();
    set_idle();
    cyc_check();
    chk("x5_after_clear", rd_data_1, 0);
    chk("x31_after_clear", rd_data_2, 0);
    @(negedge clk);

    set_in(0, 0, 0, 1, 3, 32'hDEAD_BEEF, 0, 0, 0);
    tick();
    set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_idle();
    cyc_check();
    chk("x3_readback", rd_data_1, 32'hDEAD_BEEF);
    chk("x0_readback", rd_data_2, 0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].rv, 5'($urandom), 5'($urandom),
             tbl[i].av, 5'($urandom_range(1, 31)), $urandom,
             tbl[i].lv, 5'($urandom_range(1, 31)), $urandom);
      cyc_check();
      chk("tbl_rd_ready", rd_ready, tbl[i].e_rd);
      chk("tbl_wa_ready", wa_ready, tbl[i].e_wa);
      chk("tbl_wl_ready", wl_ready, tbl[i].e_wl);
      @(negedge clk);
    end
    set_idle();
    tick();

    set_in(0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_1234);
    cyc_check();
    chk("x0_wl_ready", wl_ready, 1);
    chk("x0_rf_en", rf_en, 0);
    @(negedge clk);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_idle();
    cyc_check();
    chk("x0_read_1", rd_data_1, 0);
    chk("x0_read_2", rd_data_2, 0);
    @(negedge clk);

    rand_cycles(600);

    // Reset lands in the cycle a read is granted: its response must never appear.
    set_in(1, 4, 6, 0, 0, 0, 0, 0, 0);
    cyc_check();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drops_rvalid", rd_rvalid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < 32; i++) begin
      cyc_check();
      chk("reclear_index", rf_reg_num, i);
      @(negedge clk);
    end

    rand_cycles(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
